// File: rtl/filter_half_pkg.sv
// Shared definitions for the half-pel filter pipeline.
// Build option: define FILTER_HALF_ROUND_EN for round-half-up averaging (default truncates).
package filter_half_pkg;

  localparam logic [1:0] MODE_H = 2'd0;
  localparam logic [1:0] MODE_V = 2'd1;
  localparam logic [1:0] MODE_D = 2'd2;

`ifdef FILTER_HALF_ROUND_EN
  localparam logic RoundBit = 1'b1;
`else
  localparam logic RoundBit = 1'b0;
`endif

  // Reserved encoding behaves as horizontal, so it is folded away at latch time.
  function automatic logic [1:0] mode_norm(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_H : mode;
  endfunction

endpackage

// File: rtl/filter_half_lane.sv
// Combinational single-lane half-pel averager (avg for H/V, avg4 for D).
// Rounding follows filter_half_pkg::RoundBit (FILTER_HALF_ROUND_EN).
module filter_half_lane
  import filter_half_pkg::*;
#(
  parameter int unsigned PIX_W     = 8,
  parameter bit          LAST_LANE = 1'b0
) (
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] cur_a,
  input  logic [PIX_W-1:0] cur_b,
  input  logic [PIX_W-1:0] prev_a,
  input  logic [PIX_W-1:0] prev_b,
  output logic [PIX_W-1:0] res
);

  localparam logic [PIX_W:0]   Rnd2 = {{PIX_W{1'b0}}, RoundBit};
  localparam logic [PIX_W+1:0] Rnd4 = {{PIX_W{1'b0}}, RoundBit, 1'b0};

  logic [PIX_W:0]   sum_h;
  logic [PIX_W:0]   sum_v;
  logic [PIX_W+1:0] sum_d;
  logic [PIX_W-1:0] avg_h;
  logic [PIX_W-1:0] avg_v;
  logic [PIX_W-1:0] avg_d;

  always_comb begin
    sum_h = {1'b0, cur_a} + {1'b0, cur_b} + Rnd2;
    sum_v = {1'b0, prev_a} + {1'b0, cur_a} + Rnd2;
    sum_d = {2'b00, prev_a} + {2'b00, prev_b} + {2'b00, cur_a} + {2'b00, cur_b} + Rnd4;
    avg_h = PIX_W'(sum_h >> 1);
    avg_v = PIX_W'(sum_v >> 1);
    avg_d = PIX_W'(sum_d >> 2);
  end

  // The rightmost lane has no right neighbour in H/D and outputs zero there.
  always_comb begin
    res = '0;
    unique case (mode)
      MODE_V: res = avg_v;
      MODE_D: if (!LAST_LANE) res = avg_d;
      default: if (!LAST_LANE) res = avg_h;
    endcase
  end

endmodule

// File: rtl/filter_half_pipe.sv
// Pipelined half-pel filter: H/V/D modes, one-row line buffer, block row counting.
// Build option: FILTER_HALF_ROUND_EN selects round-half-up instead of truncation.
module filter_half_pipe
  import filter_half_pkg::*;
#(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned N_PIX    = 8,
  parameter int unsigned BLK_ROWS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [1:0]               in_mode,
  input  logic [N_PIX*PIX_W-1:0]   in_pix,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_PIX*PIX_W-1:0]   out_pix,
  output logic                     out_last,
  output logic [1:0]               out_mode
);

  localparam int unsigned    RowW    = $clog2(BLK_ROWS);
  localparam int unsigned    RowBits = N_PIX * PIX_W;
  localparam logic [RowW-1:0] LastRow = RowW'(BLK_ROWS - 1);

  logic [RowW-1:0]    row_q, row_d;
  logic [1:0]         mode_q, mode_d;
  logic               primed_q, primed_d;
  logic [RowBits-1:0] line_q;
  logic [RowBits-1:0] filt;

  logic               out_valid_q;
  logic [RowBits-1:0] out_pix_q;
  logic               out_last_q;
  logic [1:0]         out_mode_q;

  logic accept;
  logic emit;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Row state as it will be after the current input row; only committed on accept.
  always_comb begin
    mode_d   = mode_q;
    row_d    = row_q;
    primed_d = primed_q;
    if (in_sof) begin
      mode_d   = mode_norm(in_mode);
      row_d    = '0;
      primed_d = 1'b1;
    end else if (row_q != LastRow) begin
      row_d = row_q + 1'b1;
    end
    // V/D need a previous row, so the sof row only primes the buffer.
    emit = primed_d && ((mode_d == MODE_H) || (row_d != '0));
  end

  for (genvar k = 0; k < N_PIX; k++) begin : g_lane
    localparam int unsigned KB = (k < N_PIX - 1) ? k + 1 : k;

    filter_half_lane #(
      .PIX_W     (PIX_W),
      .LAST_LANE (k == N_PIX - 1)
    ) u_lane (
      .mode   (mode_d),
      .cur_a  (in_pix[k*PIX_W +: PIX_W]),
      .cur_b  (in_pix[KB*PIX_W +: PIX_W]),
      .prev_a (line_q[k*PIX_W +: PIX_W]),
      .prev_b (line_q[KB*PIX_W +: PIX_W]),
      .res    (filt[k*PIX_W +: PIX_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      mode_q      <= MODE_H;
      primed_q    <= 1'b0;
      line_q      <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_last_q  <= 1'b0;
      out_mode_q  <= MODE_H;
    end else begin
      if (accept) begin
        line_q      <= in_pix;
        row_q       <= row_d;
        mode_q      <= mode_d;
        primed_q    <= primed_d;
        out_valid_q <= emit;
        if (emit) begin
          out_pix_q  <= filt;
          out_last_q <= (row_d == LastRow);
          out_mode_q <= mode_d;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_last  = out_last_q;
  assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_filter_half_pipe.sv
// Self-checking bench for filter_half_pipe: directed cases plus random traffic vs a row-level model.
// Honours FILTER_HALF_ROUND_EN the same way as the design.
module tb_filter_half_pipe;

  localparam int PW = 8;
  localparam int N  = 8;
  localparam int B  = 8;
  localparam int W  = PW * N;
`ifdef FILTER_HALF_ROUND_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_sof;
  logic [1:0]   in_mode;
  logic [W-1:0] in_pix;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_pix;
  logic         out_last;
  logic [1:0]   out_mode;

  filter_half_pipe #(
    .PIX_W    (PW),
    .N_PIX    (N),
    .BLK_ROWS (B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_mode   (in_mode),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_last  (out_last),
    .out_mode  (out_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pix;
    logic         last;
    logic [1:0]   mode;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   prev[N];
  int   m_mode;
  int   m_row;
  bit   m_primed;
  bit   m_ovalid;
  int   n_xfer;
  int   n_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] pack(input int v[N]);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[k*PW +: PW] = PW'(v[k]);
    return r;
  endfunction

  // Row-level reference: applies the mode rules with plain integer arithmetic.
  task automatic model_accept(input bit s, input logic [1:0] md, input logic [W-1:0] px,
                              output bit emit);
    int   cur[N];
    int   v;
    exp_t e;
    for (int k = 0; k < N; k++) cur[k] = int'(px[k*PW +: PW]);
    if (s) begin
      m_mode   = (md == 2'd3) ? 0 : int'(md);
      m_row    = 0;
      m_primed = 1'b1;
    end else if (m_row < B - 1) begin
      m_row = m_row + 1;
    end
    emit = m_primed && (m_mode == 0 || m_row != 0);
    if (emit) begin
      for (int k = 0; k < N; k++) begin
        if (m_mode == 1) v = (prev[k] + cur[k] + R) / 2;
        else if (k == N - 1) v = 0;
        else if (m_mode == 0) v = (cur[k] + cur[k+1] + R) / 2;
        else v = (prev[k] + prev[k+1] + cur[k] + cur[k+1] + 2 * R) / 4;
        e.pix[k*PW +: PW] = PW'(v);
      end
      e.last = (m_row == B - 1);
      e.mode = 2'(m_mode);
      q.push_back(e);
    end
    for (int k = 0; k < N; k++) prev[k] = cur[k];
  endtask

  // Drive one cycle starting just after a posedge; checks happen on the falling edge.
  task automatic step(input bit v, input bit s, input logic [1:0] md, input logic [W-1:0] px,
                      input bit ordy);
    bit exp_rdy;
    bit emit;
    in_valid  = v;
    in_sof    = s;
    in_mode   = md;
    in_pix    = px;
    out_ready = ordy;
    @(negedge clk);
    exp_rdy = !m_ovalid || ordy;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_ovalid));
    if (m_ovalid && q.size() > 0) begin
      chk("out_pix", out_pix, q[0].pix);
      chk("out_last", 64'(out_last), 64'(q[0].last));
      chk("out_mode", 64'(out_mode), 64'(q[0].mode));
    end
    if (out_valid && ordy) begin
      n_xfer++;
      if (out_last) n_last++;
    end
    if (m_ovalid && ordy && q.size() > 0) void'(q.pop_front());
    if (v && exp_rdy) begin
      model_accept(s, md, px, emit);
      m_ovalid = emit;
    end else if (m_ovalid && ordy) begin
      m_ovalid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    for (int k = 0; k < N; k++) prev[k] = 0;
    m_mode = 0; m_row = 0; m_primed = 1'b0; m_ovalid = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pix", out_pix, 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_mode", 64'(out_mode), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  int h_row[N]  = '{10, 11, 255, 255, 0, 1, 2, 3};
  int h_rnd[N]  = '{11, 133, 255, 128, 1, 2, 3, 0};
  int h_trn[N]  = '{10, 133, 255, 127, 0, 1, 2, 0};
  int d_row0[N] = '{0, 4, 8, 12, 16, 20, 24, 28};
  int d_row1[N] = '{8, 12, 16, 20, 24, 28, 32, 36};

  initial begin
    logic [W-1:0] rowv;
    logic [W-1:0] hexp;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_mode = 2'd0; in_pix = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Horizontal, single sof row, visible one cycle later.
    hexp = (R == 1) ? pack(h_rnd) : pack(h_trn);
    step(1, 1, 2'd0, pack(h_row), 1);
    chk("h_pix", out_pix, hexp);
    step(0, 0, 2'd0, '0, 1);

    // Vertical: sof row primes, second row averages.
    step(1, 1, 2'd1, {N{8'h20}}, 1);
    chk("v_prime_none", 64'(out_valid), 64'd0);
    step(1, 0, 2'd1, {N{8'h41}}, 1);
    chk("v_pix", out_pix, (R == 1) ? {N{8'h31}} : {N{8'h30}});
    step(0, 0, 2'd1, '0, 1);

    // Diagonal.
    step(1, 1, 2'd2, pack(d_row0), 1);
    step(1, 0, 2'd2, pack(d_row1), 1);
    chk("d_lane0", 64'(out_pix[PW-1:0]), 64'd6);
    step(0, 0, 2'd2, '0, 1);

    // Backpressure: stall five cycles with a row offered, then release.
    step(1, 1, 2'd1, {$urandom(), $urandom()}, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 2'd1, {$urandom(), $urandom()}, 0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 6; i++) step(1, 0, 2'd1, {$urandom(), $urandom()}, 1);
    step(0, 0, 2'd0, '0, 1);

    // Full V block: 7 outputs, single out_last; then overrun and restart.
    n_xfer = 0; n_last = 0;
    step(1, 1, 2'd1, {$urandom(), $urandom()}, 1);
    for (int i = 1; i < B; i++) step(1, 0, 2'd1, {$urandom(), $urandom()}, 1);
    step(0, 0, 2'd0, '0, 1);
    chk("blk_count", 64'(n_xfer), 64'd7);
    chk("blk_last", 64'(n_last), 64'd1);
    step(1, 0, 2'd1, {$urandom(), $urandom()}, 1);
    chk("sat_last", 64'(out_last), 64'd1);
    step(1, 1, 2'd1, {$urandom(), $urandom()}, 1);
    chk("restart_prime", 64'(out_valid), 64'd0);
    step(0, 0, 2'd0, '0, 1);

    // Reset with a pending output, then an unprimed row.
    step(1, 1, 2'd0, pack(h_row), 0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    do_reset();
    rowv = {$urandom(), $urandom()};
    step(1, 0, 2'd0, rowv, 1);
    chk("unprimed_none", 64'(out_valid), 64'd0);
    step(0, 0, 2'd0, '0, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom() % 4) != 0, ($urandom() % 6) == 0, 2'($urandom()),
           {$urandom(), $urandom()}, ($urandom() % 4) != 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'd0, '0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
